// File: rtl/av_resp_pkg.sv
// Shared types and constants for the av_config I2C responder.
package av_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    REG_HI,
    ACK_HI,
    DATA_LO,
    ACK_LO,
    IGNORE
  } state_t;

  localparam logic [6:0] RESET_REG        = 7'h0F;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

  function automatic logic is_data_state(input state_t s);
    return (s == ADDR) || (s == REG_HI) || (s == DATA_LO);
  endfunction

endpackage

// File: rtl/av_resp_line_sync.sv
// Bus line synchronizer with registered rise/fall detect; optional 3-sample
// stability filter enabled by AV_RESP_GLITCH_FILTER_EN.
module av_resp_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_rise;
  logic r_fall;
  logic w_clean;

  // Idle bus level is high, so reset to 1 to avoid spurious edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
    end
  end

`ifdef AV_RESP_GLITCH_FILTER_EN
  logic r_h1;
  logic r_h2;
  logic r_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h1   <= 1'b1;
      r_h2   <= 1'b1;
      r_hold <= 1'b1;
    end else begin
      r_h1   <= r_s2;
      r_h2   <= r_h1;
      r_hold <= w_clean;
    end
  end

  always_comb begin
    w_clean = r_hold;
    if ((r_s2 == r_h1) && (r_h1 == r_h2)) w_clean = r_s2;
  end
`else
  always_comb w_clean = r_s2;
`endif

  // o_level is the delayed copy so it lines up with the registered edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_clean;
      r_rise <= w_clean & ~r_prev;
      r_fall <= ~w_clean & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/av_config_responder.sv
// WM8731-style write-only I2C register target for the av_config bus.
// Optional input glitch filter: define AV_RESP_GLITCH_FILTER_EN.
module av_config_responder
  import av_resp_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       sclk,
  input  logic       sdat_in,
  output logic       sdat_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy,
  output logic [7:0] nack_cnt
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_byte_end;
  logic w_nack, w_commit, w_latch_reg;
  logic [8:0] w_wdata;

  state_t r_state, w_next;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_done;
  logic [6:0] r_reg_addr;
  logic       r_d8;
  logic       r_wr_valid;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;
  logic [7:0] r_nack_cnt;
  logic [8:0] r_regs [NUM_REGS];

  av_resp_line_sync u_scl (
    .i_clk  (clk_clk),
    .i_rst  (reset_reset),
    .i_line (sclk),
    .o_level(w_scl_lvl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  av_resp_line_sync u_sda (
    .i_clk  (clk_clk),
    .i_rst  (reset_reset),
    .i_line (sdat_in),
    .o_level(w_sda_lvl),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start    = w_sda_fall & w_scl_lvl;
  assign w_stop     = w_sda_rise & w_scl_lvl;
  // The falling SCLK after the 8th bit is where ACK/NACK is decided.
  assign w_byte_end = w_scl_fall & r_byte_done;
  assign w_wdata    = {r_d8, r_shift};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_nack      = 1'b0;
    w_commit    = 1'b0;
    w_latch_reg = 1'b0;
    if (w_stop) begin
      w_next = IDLE;
    end else if (w_start) begin
      w_next = ADDR;
    end else begin
      unique case (r_state)
        ADDR: if (w_byte_end) begin
          if ((r_shift[7:1] == DEV_ADDR) && !r_shift[0]) begin
            w_next = ACK_ADDR;
          end else begin
            w_next = IGNORE;
            w_nack = 1'b1;
          end
        end
        ACK_ADDR: if (w_scl_fall) w_next = REG_HI;
        REG_HI: if (w_byte_end) begin
          if (32'(r_shift[7:1]) < NUM_REGS) begin
            w_next      = ACK_HI;
            w_latch_reg = 1'b1;
          end else begin
            w_next = IGNORE;
            w_nack = 1'b1;
          end
        end
        ACK_HI:  if (w_scl_fall) w_next = DATA_LO;
        DATA_LO: if (w_byte_end) w_next = ACK_LO;
        ACK_LO: if (w_scl_fall) begin
          w_next   = IGNORE;
          w_commit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
      r_reg_addr  <= '0;
      r_d8        <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_nack_cnt  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_valid <= w_commit;
      if (w_start || w_stop || w_byte_end) begin
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
      end else if (w_scl_rise && !r_byte_done && is_data_state(r_state)) begin
        r_shift   <= {r_shift[6:0], w_sda_lvl};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
      end
      if (w_latch_reg) begin
        r_reg_addr <= r_shift[7:1];
        r_d8       <= r_shift[0];
      end
      if (w_commit) begin
        r_wr_addr <= r_reg_addr;
        r_wr_data <= w_wdata;
        if ((r_reg_addr == RESET_REG) && (w_wdata == '0)) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
          r_regs[r_reg_addr[AW-1:0]] <= w_wdata;
        end
      end
      if (w_nack && (r_nack_cnt != '1)) r_nack_cnt <= r_nack_cnt + 8'd1;
    end
  end

  assign sdat_oe  = (r_state == ACK_ADDR) || (r_state == ACK_HI) || (r_state == ACK_LO);
  assign busy     = (r_state != IDLE);
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign nack_cnt = r_nack_cnt;
  assign rd_data  = r_regs[rd_addr];

endmodule
